// File: rtl/clock_divider.sv
// Integer clock divider: registered div_clk, low for LOW then high for HIGH clkIn cycles.
// Define CLKDIV_ODD_DUTY50_EN to stretch the high phase by half a cycle for odd DIVIDE (50% duty).
`timescale 1ns/1ps
module clock_divider #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OUT_FREQ_HZ = 1,
    parameter int DIVIDE      = CLK_FREQ_HZ / OUT_FREQ_HZ,
    parameter int CNT_W       = $clog2(DIVIDE)
) (
    input  logic clkIn,
    input  logic rst,
    output logic div_clk
);

    localparam int HIGH = DIVIDE / 2;
    localparam int LOW  = DIVIDE - HIGH;
    localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(LOW - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);

    generate
        if (DIVIDE < 2) begin : g_bad_divide
            $error("clock_divider: DIVIDE must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        q_d   = q_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            q_d   = 1'b0;
        end else if (cnt_q == CNT_RISE) begin
            q_d   = 1'b1;
        end
    end

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

`ifdef CLKDIV_ODD_DUTY50_EN
    generate
        if (DIVIDE % 2 == 1) begin : g_odd50
            // Half-cycle delayed copy of q extends the high phase past the rising edge that clears q.
            logic qn_q, qn_d;

            always_comb qn_d = q_q;

            always_ff @(negedge clkIn or posedge rst) begin
                if (rst) qn_q <= 1'b0;
                else     qn_q <= qn_d;
            end

            assign div_clk = q_q | qn_q;
        end else begin : g_even
            assign div_clk = q_q;
        end
    endgenerate
`else
    assign div_clk = q_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Randomized-reset bench for clock_divider: five parameterizations checked against a
// phase-arithmetic reference model sampled 1 ns after every clkIn rising edge.
`timescale 1ns/1ps
module tb_clock_divider;

    localparam int NDUT = 5;
`ifdef CLKDIV_ODD_DUTY50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic clkIn = 1'b0;
    logic rst;
    logic o4, o5, o10, o2, o100;

    int divs [NDUT] = '{4, 5, 10, 2, 100};
    int n_chk = 0;
    int n_err = 0;
    int k     = 0;   // clkIn rising edges since the last reset release

    clock_divider #(.DIVIDE(4))  u_d4  (.clkIn(clkIn), .rst(rst), .div_clk(o4));
    clock_divider #(.DIVIDE(5))  u_d5  (.clkIn(clkIn), .rst(rst), .div_clk(o5));
    clock_divider #(.DIVIDE(10)) u_d10 (.clkIn(clkIn), .rst(rst), .div_clk(o10));
    clock_divider #(.DIVIDE(2))  u_d2  (.clkIn(clkIn), .rst(rst), .div_clk(o2));
    clock_divider #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(10))
                                 u_d100 (.clkIn(clkIn), .rst(rst), .div_clk(o100));

    always #5 clkIn = ~clkIn;

    function automatic logic get_out(int i);
        case (i)
            0:       return o4;
            1:       return o5;
            2:       return o10;
            3:       return o2;
            default: return o100;
        endcase
    endfunction

    // After kk edges the output is high exactly when kk mod d lies in the last floor(d/2) slots.
    function automatic bit base_out(int d, int kk);
        return (kk % d) >= (d - d / 2);
    endfunction

    // With the odd-duty extension, a sample just after an edge still sees the previous phase's high.
    function automatic bit ref_out(int d, int kk);
        bit r;
        r = base_out(d, kk);
        if (ODD50 && (d % 2 == 1) && kk >= 1) r = r | base_out(d, kk - 1);
        return r;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("d%0d_k%0d", divs[i], k), int'(get_out(i)), int'(ref_out(divs[i], k)));
    endtask

    task automatic check_zero(string tag);
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("%s_d%0d", tag, divs[i]), int'(get_out(i)), 0);
    endtask

    task automatic tick();
        @(posedge clkIn);
        k++;
        #1;
        check_all();
    endtask

    // Called 1 ns after a rising edge: asserts reset between edges, holds it, releases between edges.
    task automatic rst_pulse(int hold);
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        repeat (hold) begin
            @(posedge clkIn);
            #1 check_zero("rst_held");
        end
        #3 rst = 1'b0;
        k = 0;
    endtask

    initial begin
        int  rises [NDUT];
        int  exp_r [NDUT];
        bit  prev  [NDUT];
        bit  cur;

        rst = 1'b1;
        repeat (3) @(posedge clkIn);
        #1 check_zero("reset_state");
        #2 rst = 1'b0;
        k = 0;

        // Reset while DIVIDE=10 output is high, then a full low phase must follow.
        repeat (7) tick();
        chk("d10_high_pre_rst", int'(o10), 1);
        rst_pulse(0);
        chk("d10_low_post_rst", int'(o10), 0);
        repeat (20) tick();

        repeat (3000) begin
            tick();
            if ($urandom_range(0, 99) == 0) rst_pulse(int'($urandom_range(0, 3)));
        end

        // Rising-edge count over 1000 clkIn cycles from a clean release.
        rst_pulse(1);
        for (int i = 0; i < NDUT; i++) begin
            rises[i] = 0;
            prev[i]  = 1'b0;
            exp_r[i] = 0;
            for (int kk = 1; kk <= 1000; kk++)
                if (ref_out(divs[i], kk) && !ref_out(divs[i], kk - 1)) exp_r[i]++;
        end
        repeat (1000) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                cur = get_out(i);
                if (cur && !prev[i]) rises[i]++;
                prev[i] = cur;
            end
        end
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("rises_1000_d%0d", divs[i]), rises[i], exp_r[i]);
        chk("d5_rises_200", rises[1], 200);
        chk("d100_rises_10", rises[4], 10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
